// File: rtl/gpio_port_pkg.sv
// Shared definitions for the GPIO responder: register offsets within the
// word window, the window base used by the memory-stage decoder, and the
// byte-enable expansion helper shared by every writable register.
package gpio_port_pkg;

    // Word offsets inside the GPIO register window
    localparam logic [2:0] GPIO_DATA_OUT = 3'd0;
    localparam logic [2:0] GPIO_DIR      = 3'd1;
    localparam logic [2:0] GPIO_DATA_IN  = 3'd2;
    localparam logic [2:0] GPIO_RISE_EN  = 3'd3;
    localparam logic [2:0] GPIO_FALL_EN  = 3'd4;
    localparam logic [2:0] GPIO_STATUS   = 3'd5;
    localparam logic [2:0] GPIO_SET      = 3'd6;
    localparam logic [2:0] GPIO_CLR      = 3'd7;

    // Word address of the window base; the memory stage compares the upper
    // address bits against this to raise sel.
    localparam logic [31:0] GPIO_BASE_WORD = 32'h0000_4000;

    // Expand the per-byte write enables into a per-bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Input synchronizer for the GPIO pins plus a one-flop history for edge detect.
// Latency: pin -> data after SYNC_STAGES edges; rise/fall are combinational on data/prev.
// Backpressure: none, free-running every cycle.
// Ports: clk/reset (sync, active-high); pins in; data, rise, fall out (32 bits each).
module gpio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pins,
    output logic [31:0] data,
    output logic [31:0] rise,
    output logic [31:0] fall
);

    logic [31:0] chain [SYNC_STAGES];
    logic [31:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign data = chain[SYNC_STAGES-1];
    assign rise = data & ~prev;
    assign fall = ~data & prev;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: output/direction regs, synchronized input, edge status + irq.
// Latency: rdata registered one cycle after the address; pin -> STATUS/irq after SYNC_STAGES+1 edges.
// Backpressure: none, every access completes in one cycle.
// Ports: clk/reset (sync, active-high); sel/we/addr/wdata bus in; rdata, irq out; gpio pins inout.
module gpio_port
    import gpio_port_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = 32'h0000_0000,
    parameter logic [31:0] RESET_DIR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [3:0]  we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    inout  wire  [31:0] gpio
);

    logic [31:0] data_out;
    logic [31:0] dir;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] status;
    logic [31:0] status_nxt;
    logic [31:0] data_in;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] wmask;
    logic [31:0] wbits;
    logic [31:0] clear;
    logic [31:0] rd_mux;
    logic        rd;

    gpio_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .pins  (gpio),
        .data  (data_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign wmask = byte_mask(we);
    assign wbits = wdata & wmask;
    assign rd    = sel && (we == 4'b0000);

    // A fresh edge outranks a same-cycle clear so no event is ever lost
    assign clear      = (sel && addr == GPIO_STATUS) ? wbits : '0;
    assign status_nxt = (status & ~clear) | (rise & rise_en) | (fall & fall_en);

    always_comb begin
        rd_mux = '0;
        case (addr)
            GPIO_DATA_OUT: rd_mux = data_out;
            GPIO_DIR:      rd_mux = dir;
            GPIO_DATA_IN:  rd_mux = data_in;
            GPIO_RISE_EN:  rd_mux = rise_en;
            GPIO_FALL_EN:  rd_mux = fall_en;
            GPIO_STATUS:   rd_mux = status;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            rise_en  <= '0;
            fall_en  <= '0;
            status   <= '0;
            irq      <= 1'b0;
            rdata    <= '0;
        end else begin
            status <= status_nxt;
            irq    <= |status_nxt;
            if (rd) begin
                rdata <= rd_mux;
            end
            if (sel) begin
                case (addr)
                    GPIO_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
                    GPIO_DIR:      dir      <= (dir & ~wmask) | wbits;
                    GPIO_RISE_EN:  rise_en  <= (rise_en & ~wmask) | wbits;
                    GPIO_FALL_EN:  fall_en  <= (fall_en & ~wmask) | wbits;
                    GPIO_SET:      data_out <= data_out | wbits;
                    GPIO_CLR:      data_out <= data_out & ~wbits;
                    default:       ;
                endcase
            end
        end
    end

    // Per-pin tristate: drive only where the direction bit selects output
    for (genvar i = 0; i < 32; i++) begin : g_pin
        assign gpio[i] = dir[i] ? data_out[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register access, pin drive, edge capture and reset priority.
// All bus activity is launched and sampled on the falling clock edge.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [3:0]  we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    wire  [31:0] gpio;

    logic [31:0] ext_en;
    logic [31:0] ext_val;
    logic [31:0] rd_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 32; i++) begin : g_ext
        assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    gpio_port #(
        .SYNC_STAGES (2),
        .RESET_OUT   (32'h0000_0000),
        .RESET_DIR   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .gpio  (gpio)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks are entered at a falling edge and return at a falling edge
    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] w);
        sel = 1'b1; addr = a; wdata = d; we = w;
        @(negedge clk);
        sel = 1'b0; we = 4'b0000;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; addr = a; we = 4'b0000;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        sel     = 1'b0;
        we      = 4'b0000;
        addr    = 3'd0;
        wdata   = '0;
        ext_en  = 32'hFFFF_FFFF;
        ext_val = 32'h0000_0000;
        idle(4);
        reset = 1'b0;
        idle(1);

        // Reset state: every register reads zero, irq low
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), rd_val);
            check($sformatf("reset_rd_%0d", a), rd_val, 32'h0);
        end
        check("reset_irq", {31'h0, irq}, 32'h0);

        // Output drive on the low byte only; tb keeps the upper pins at a distinct pattern
        ext_en  = 32'hFFFF_FF00;
        ext_val = 32'h5A5A_5A00;
        bus_wr(3'd1, 32'h0000_00FF, 4'b1111);
        bus_wr(3'd0, 32'hA5A5_A5A5, 4'b1111);
        check("pin_low_byte", {24'h0, gpio[7:0]}, 32'h0000_00A5);
        check("pin_high_undriven", {8'h0, gpio[31:8]}, 32'h005A_5A5A);

        bus_wr(3'd0, 32'h0000_003C, 4'b0001);
        bus_rd(3'd0, rd_val);
        check("byte_write", rd_val, 32'hA5A5_A53C);

        bus_wr(3'd6, 32'h0000_0003, 4'b1111);
        bus_wr(3'd7, 32'h0000_0020, 4'b1111);
        bus_rd(3'd0, rd_val);
        check("set_clr", rd_val, 32'hA5A5_A51F);
        check("set_clr_pins", {24'h0, gpio[7:0]}, 32'h0000_001F);
        bus_rd(3'd6, rd_val);
        check("set_reads_0", rd_val, 32'h0);
        bus_rd(3'd7, rd_val);
        check("clr_reads_0", rd_val, 32'h0);

        // Hand pin 4 over to the bench, let the synchronizer settle, enable rise capture
        bus_wr(3'd1, 32'h0000_00EF, 4'b0001);
        ext_en[4]  = 1'b1;
        ext_val[4] = 1'b0;
        idle(4);
        bus_wr(3'd3, 32'h0000_0010, 4'b0001);
        bus_rd(3'd5, rd_val);
        check("status_idle", rd_val, 32'h0);

        // Rise on pin 4 before edge N, with a DATA_IN read held across the following edges
        ext_val[4] = 1'b1;
        sel = 1'b1; addr = 3'd2; we = 4'b0000;
        @(negedge clk);                       // after edge N
        @(negedge clk);                       // after edge N+1
        check("din_n1", {31'h0, rdata[4]}, 32'h0);
        check("irq_n1", {31'h0, irq}, 32'h0);
        @(negedge clk);                       // after edge N+2
        sel = 1'b0;
        check("din_n2", {31'h0, rdata[4]}, 32'h1);
        check("irq_n2", {31'h0, irq}, 32'h1);
        bus_rd(3'd5, rd_val);
        check("status_rise", rd_val, 32'h0000_0010);

        // Fall with FALL_EN clear leaves STATUS alone
        ext_val[4] = 1'b0;
        idle(4);
        bus_rd(3'd5, rd_val);
        check("status_fall_ign", rd_val, 32'h0000_0010);

        // Write-1-to-clear
        bus_wr(3'd5, 32'h0000_0010, 4'b0001);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        bus_rd(3'd5, rd_val);
        check("status_cleared", rd_val, 32'h0);

        // Re-arm the bit, then land a new rise exactly on the clear edge
        ext_val[4] = 1'b1;
        idle(4);
        ext_val[4] = 1'b0;
        idle(4);
        bus_rd(3'd5, rd_val);
        check("status_rearmed", rd_val, 32'h0000_0010);
        ext_val[4] = 1'b1;                    // before edge N
        idle(2);                              // after edge N+1
        bus_wr(3'd5, 32'h0000_0010, 4'b0001); // clear lands on edge N+2
        check("irq_edge_wins", {31'h0, irq}, 32'h1);
        bus_rd(3'd5, rd_val);
        check("status_edge_wins", rd_val, 32'h0000_0010);

        // Reset over a DIR write: write discarded, state and rdata cleared
        bus_rd(3'd0, rd_val);
        check("pre_reset_rd", rd_val, 32'hA5A5_A51F);
        reset = 1'b1;
        bus_wr(3'd1, 32'hFFFF_FFFF, 4'b1111);
        reset = 1'b0;
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        bus_rd(3'd1, rd_val);
        check("rst_dir", rd_val, 32'h0);
        bus_rd(3'd5, rd_val);
        check("rst_status", rd_val, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound on the run so a stuck bench still ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
